// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Multi-channel push-button debouncer with press/release pulses, sticky
// press-event flags and a maskable level interrupt.
//
// Parameters
//   N_BTN            number of independent button channels
//   DEBOUNCE_CYCLES  consecutive sys_clk edges the synchronized input must
//                    disagree with btn_state before btn_state follows it
//                    (legal range 2..2^24)
//
// Ports
//   sys_clk      in   single clock, all state lives here
//   sys_rst      in   asynchronous active-high reset
//   btn_in       in   raw asynchronous pad levels, 1 = pressed
//   irq_mask     in   per-channel interrupt enable
//   evt_clear    in   write-1-to-clear strobe for evt_pending
//   btn_state    out  debounced level
//   btn_press    out  one-cycle pulse on each debounced 0->1 transition
//   btn_release  out  one-cycle pulse on each debounced 1->0 transition
//   evt_pending  out  sticky press-event flags
//   irq          out  combinational OR over (evt_pending & irq_mask)
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned N_BTN           = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [N_BTN-1:0] btn_in,
  input  logic [N_BTN-1:0] irq_mask,
  input  logic [N_BTN-1:0] evt_clear,
  output logic [N_BTN-1:0] btn_state,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] evt_pending,
  output logic             irq
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0]            sync1;
  logic [N_BTN-1:0]            sync2;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_q;
  logic [N_BTN-1:0][CNT_W-1:0] cnt_d;
  logic [N_BTN-1:0]            state_d;
  logic [N_BTN-1:0]            press_d;
  logic [N_BTN-1:0]            release_d;
  logic [N_BTN-1:0]            pending_d;

  // Per-channel debounce: count edges of disagreement, flip state on the last one.
  // The press/release pulses are computed alongside the state flip so they
  // appear in the same cycle btn_state first shows its new value.
  always_comb begin
    cnt_d     = '0;
    state_d   = btn_state;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sync2[i] != btn_state[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          state_d[i]   = sync2[i];
          press_d[i]   = sync2[i];
          release_d[i] = ~sync2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky event flags: a press arriving with a clear wins.
  always_comb begin
    pending_d = (evt_pending & ~evt_clear) | btn_press;
  end

  // State registers, including the 2-flop input synchronizer.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1       <= '0;
      sync2       <= '0;
      cnt_q       <= '0;
      btn_state   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      evt_pending <= '0;
    end else begin
      sync1       <= btn_in;
      sync2       <= sync1;
      cnt_q       <= cnt_d;
      btn_state   <= state_d;
      btn_press   <= press_d;
      btn_release <= release_d;
      evt_pending <= pending_d;
    end
  end

  // Mask changes must reach irq without a clock edge.
  assign irq = |(evt_pending & irq_mask);

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, N_BTN=6.
// Inputs change 1 time unit after a rising edge; outputs are observed at that
// same point, so "after edge j" means the values registered by edge j.
// ---------------------------------------------------------------------------
module tb_btn_debounce;

  localparam int unsigned N  = 6;
  localparam int unsigned DC = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_in;
  logic [N-1:0] irq_mask;
  logic [N-1:0] evt_clear;
  logic [N-1:0] btn_state;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] evt_pending;
  logic         irq;

  int total;
  int bad;

  btn_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(DC)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .btn_in     (btn_in),
    .irq_mask   (irq_mask),
    .evt_clear  (evt_clear),
    .btn_state  (btn_state),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .evt_pending(evt_pending),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"},   32'(btn_state),   32'h0);
    check({tag, ".press"},   32'(btn_press),   32'h0);
    check({tag, ".release"}, 32'(btn_release), 32'h0);
    check({tag, ".pending"}, 32'(evt_pending), 32'h0);
    check({tag, ".irq"},     32'(irq),         32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    btn_in    = '0;
    irq_mask  = 6'b111111;
    evt_clear = '0;

    // Reset values, before any clock edge
    #2;
    check_all_zero("reset");
    step(3);
    rst      = 1'b0;
    irq_mask = '0;
    step(4);
    check("idle.state", 32'(btn_state), 32'h0);

    // Channel 0 press: state/press at k+5, pending at k+6
    btn_in[0] = 1'b1;
    step(5);
    check("p0.k4.state", 32'(btn_state), 32'h00);
    check("p0.k4.press", 32'(btn_press), 32'h00);
    step(1);
    check("p0.k5.state",   32'(btn_state),   32'h01);
    check("p0.k5.press",   32'(btn_press),   32'h01);
    check("p0.k5.pending", 32'(evt_pending), 32'h00);
    step(1);
    check("p0.k6.press",   32'(btn_press),   32'h00);
    check("p0.k6.pending", 32'(evt_pending), 32'h01);
    check("p0.k6.state",   32'(btn_state),   32'h01);

    // Channel 1 press, then irq masking and write-1-to-clear
    btn_in[1] = 1'b1;
    step(7);
    check("p1.pending", 32'(evt_pending), 32'h03);
    irq_mask = 6'b000010;
    #1;
    check("irq.mask1", 32'(irq), 32'h1);
    irq_mask = 6'b000000;
    #1;
    check("irq.mask0", 32'(irq), 32'h0);
    evt_clear = 6'b000010;
    step(1);
    evt_clear = '0;
    check("clr1.pending", 32'(evt_pending), 32'h01);
    irq_mask = 6'b000010;
    #1;
    check("clr1.irq", 32'(irq), 32'h0);
    irq_mask = '0;
    evt_clear = 6'b000001;
    step(1);
    evt_clear = '0;
    check("clr0.pending", 32'(evt_pending), 32'h00);

    // Channel 2 glitch of 3 sampling edges: no effect
    btn_in[2] = 1'b1;
    step(3);
    btn_in[2] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("glitch.state",   32'(btn_state),   32'h03);
      check("glitch.pulses",  32'(btn_press | btn_release), 32'h00);
    end
    step(8);
    check("glitch.end.state", 32'(btn_state), 32'h03);

    // Channel 2 excursion of exactly 4 sampling edges: rises, then releases
    btn_in[2] = 1'b1;
    step(4);
    btn_in[2] = 1'b0;
    step(2);
    check("exc.k5.state", 32'(btn_state), 32'h07);
    check("exc.k5.press", 32'(btn_press), 32'h04);
    step(3);
    check("exc.k8.release", 32'(btn_release), 32'h00);
    check("exc.k8.state",   32'(btn_state),   32'h07);
    step(1);
    check("exc.k9.release", 32'(btn_release), 32'h04);
    check("exc.k9.press",   32'(btn_press),   32'h00);
    check("exc.k9.state",   32'(btn_state),   32'h03);

    // Channel 3 press coinciding with its clear strobe: set wins
    btn_in[3] = 1'b1;
    step(6);
    check("sc.press", 32'(btn_press), 32'h08);
    evt_clear = 6'b001000;
    step(1);
    evt_clear = '0;
    check("sc.pending", 32'(evt_pending), 32'h0C);
    evt_clear = 6'b001100;
    step(1);
    evt_clear = '0;
    check("sc.cleared", 32'(evt_pending), 32'h00);

    // All buttons held through reset deassertion
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("rst2");
    btn_in = 6'b111111;
    step(3);
    rst = 1'b0;
    step(5);
    check("hold.k4.press", 32'(btn_press), 32'h00);
    step(1);
    check("hold.k5.press", 32'(btn_press), 32'h3F);
    check("hold.k5.state", 32'(btn_state), 32'h3F);
    step(1);
    check("hold.k6.press",   32'(btn_press),   32'h00);
    check("hold.k6.pending", 32'(evt_pending), 32'h3F);
    irq_mask = 6'b111111;
    #1;
    check("hold.irq", 32'(irq), 32'h1);

    // Back to idle under reset
    rst    = 1'b1;
    btn_in = '0;
    step(2);
    rst = 1'b0;
    step(3);
    check_all_zero("idle2");

    // Reset asserted mid-count on channel 4: partial count is discarded
    btn_in[4] = 1'b1;
    step(4);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("mid");
    btn_in[4] = 1'b0;
    step(2);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      check("mid.after.press", 32'(btn_press), 32'h00);
      check("mid.after.state", 32'(btn_state), 32'h00);
    end

    // Re-qualify channel 4
    btn_in[4] = 1'b1;
    step(6);
    check("req.press", 32'(btn_press), 32'h10);
    check("req.state", 32'(btn_state), 32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter N_BTN, default 6: number of independent button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000: number of consecutive sys_clk edges the synchronized input must differ from btn_state before btn_state changes; legal range 2..2^24.
REQ-003 SHALL have port sys_clk  input  1  single clock; all state in this domain.
REQ-004 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_in  input  N_BTN  raw, asynchronous button pad levels, 1 = pressed.
REQ-006 SHALL have port irq_mask  input  N_BTN  per-channel interrupt enable.
REQ-007 SHALL have port evt_clear  input  N_BTN  write-1-to-clear strobe for evt_pending, one bit per channel.
REQ-008 SHALL have port btn_state  output  N_BTN  debounced level.
REQ-009 SHALL have port btn_press  output  N_BTN  one-cycle pulse on each debounced 0->1 transition.
REQ-010 SHALL have port btn_release  output  N_BTN  one-cycle pulse on each debounced 1->0 transition.
REQ-011 SHALL have port evt_pending  output  N_BTN  sticky press-event flags.
REQ-012 SHALL have port irq  output  1  level interrupt = OR over (evt_pending AND irq_mask).

Function
REQ-013 SHALL pass each btn_in bit through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-014 SHALL keep, per channel, a counter of width clog2(DEBOUNCE_CYCLES) and a btn_state register.
REQ-015 Per channel, each edge: if sync2 == btn_state, counter <= 0.
REQ-016 Per channel, each edge: if sync2 != btn_state and counter < DEBOUNCE_CYCLES-1, counter <= counter+1.
REQ-017 Per channel, each edge: if sync2 != btn_state and counter == DEBOUNCE_CYCLES-1, btn_state <= sync2 and counter <= 0.
REQ-018 Latency: a new btn_in level first sampled at edge k and held stable SHALL appear on btn_state at edge k+DEBOUNCE_CYCLES+1.
REQ-019 A btn_in excursion held for fewer than DEBOUNCE_CYCLES sampling edges SHALL NOT change btn_state; excursions of DEBOUNCE_CYCLES or more SHALL.
REQ-020 btn_press/btn_release SHALL be registered and high for exactly the one cycle in which btn_state first shows its new value.
REQ-021 btn_press and btn_release SHALL never be high together on the same channel.
REQ-022 evt_pending[i] SHALL set on the edge after btn_press[i] is high.
REQ-023 evt_pending[i] SHALL clear on the edge after evt_clear[i] is sampled high.
REQ-024 Simultaneous set and clear on the same channel: set SHALL win and evt_pending stays 1.
REQ-025 irq SHALL be combinational from evt_pending and irq_mask; a mask change SHALL affect irq in the same cycle.
REQ-026 Channels SHALL be fully independent; activity on one channel SHALL not alter timing of another.
REQ-027 The counter SHALL never wrap; it saturates at DEBOUNCE_CYCLES-1 only as the transition point of REQ-017.

Reset
REQ-028 While sys_rst is high, sync1, sync2, counters, btn_state, btn_press, btn_release, evt_pending SHALL be 0, and hence irq = 0, independent of sys_clk.
REQ-029 A button held pressed through reset deassertion SHALL be treated as a new press: btn_press pulses DEBOUNCE_CYCLES+1 edges after the first post-reset sampling edge.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count; no press or release pulse SHALL result from a pre-reset partial count.

Verification (DEBOUNCE_CYCLES=4, N_BTN=6)
REQ-031 btn_in[0] 0->1, held -> btn_state[0] = 1 and btn_press[0] high exactly at edge k+5, evt_pending[0] = 1 at k+6; other channels unchanged.
REQ-032 btn_in[2] high for 3 cycles then low -> btn_state[2] stays 0, no pulses; same input held high for 4 cycles -> btn_state[2] rises, then btn_release[2] pulses after the falling edge is debounced.
REQ-033 evt_pending[1] = 1, irq_mask = 6'b000010 -> irq = 1; irq_mask = 0 -> irq = 0 in the same cycle; evt_clear[1] pulse -> evt_pending[1] = 0 next edge.
REQ-034 btn_press[3] and evt_clear[3] both high in the same cycle -> evt_pending[3] = 1 afterwards.
REQ-035 btn_in = 6'b111111 held across sys_rst deassertion -> all six btn_press bits pulse together 5 edges after release.
REQ-036 sys_rst asserted asynchronously 2 cycles into a debounce count -> all outputs 0 immediately, with no pulse after release unless btn_in is re-qualified for 4 sampling edges.
